// File: rtl/updown_counter.sv
// updown_counter: registered up/down counter with programmable modulus, clamped
// parallel load, enable, terminal-count status and boundary pulses.
// Build option: define UPDOWN_COUNTER_SAT_EN to saturate at the boundaries instead of wrapping.
// Revision: 1.0

`default_nettype none

module updown_counter #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Value the counter takes when a step is attempted at a boundary.
`ifdef UPDOWN_COUNTER_SAT_EN
  localparam logic [WIDTH-1:0] C_UP_BOUND = MAX_VAL;
  localparam logic [WIDTH-1:0] C_DN_BOUND = C_ZERO;
`else
  localparam logic [WIDTH-1:0] C_UP_BOUND = C_ZERO;
  localparam logic [WIDTH-1:0] C_DN_BOUND = MAX_VAL;
`endif

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_count == MAX_VAL);
  assign w_at_zero = (r_count == C_ZERO);

  always_comb begin
    w_count_nxt = r_count;
    w_ovf_nxt   = 1'b0;
    w_unf_nxt   = 1'b0;
    if (load) begin
      // Out-of-range loads clamp so the count can never exceed MAX_VAL.
      w_count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (w_at_max) begin
          w_count_nxt = C_UP_BOUND;
          w_ovf_nxt   = 1'b1;
        end else begin
          w_count_nxt = r_count + C_ONE;
        end
      end else begin
        if (w_at_zero) begin
          w_count_nxt = C_DN_BOUND;
          w_unf_nxt   = 1'b1;
        end else begin
          w_count_nxt = r_count - C_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= C_ZERO;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  assign count = r_count;
  assign ovf   = r_ovf;
  assign unf   = r_unf;
  assign zero  = w_at_zero;
  assign tc    = up_dn ? w_at_max : w_at_zero;

endmodule

`default_nettype wire

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed self-checking bench for updown_counter (WIDTH=8, MAX_VAL=9).
// Revision: 1.0

`default_nettype none

module tb_updown_counter;

  localparam int unsigned WIDTH = 8;
  localparam logic [7:0]  MAXV  = 8'd9;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             zero;
  logic             ovf;
  logic             unf;

  int n_vec;
  int n_err;

  updown_counter #(.WIDTH(WIDTH), .MAX_VAL(MAXV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .zero     (zero),
    .ovf      (ovf),
    .unf      (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] c, input logic o, input logic u);
    check({tag, ".count"}, {24'd0, count}, {24'd0, c});
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, o});
    check({tag, ".unf"}, {31'd0, unf}, {31'd0, u});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 8'h55;

    // Reset dominates load and enable.
    step(); step();
    chk_all("reset", 8'd0, 1'b0, 1'b0);
    check("reset.zero", {31'd0, zero}, 32'd1);
    check("reset.tc_up", {31'd0, tc}, 32'd0);
    up_dn = 1'b0; #1;
    check("reset.tc_dn", {31'd0, tc}, 32'd1);

    rst_n = 1'b1; load = 1'b0; up_dn = 1'b1;
    step(); chk_all("run1", 8'd1, 1'b0, 1'b0);
    check("run1.zero", {31'd0, zero}, 32'd0);
    step(); chk_all("run2", 8'd2, 1'b0, 1'b0);
    step(); chk_all("run3", 8'd3, 1'b0, 1'b0);

    // Upper boundary.
    load = 1'b1; load_val = 8'd9;
    step(); chk_all("ld9", 8'd9, 1'b0, 1'b0);
    check("ld9.tc", {31'd0, tc}, 32'd1);
    load = 1'b0;
`ifdef UPDOWN_COUNTER_SAT_EN
    step(); chk_all("up_bound1", 8'd9, 1'b1, 1'b0);
    step(); chk_all("up_bound2", 8'd9, 1'b1, 1'b0);
    en = 1'b0;
    step(); chk_all("up_hold", 8'd9, 1'b0, 1'b0);
`else
    step(); chk_all("up_bound1", 8'd0, 1'b1, 1'b0);
    check("up_bound1.tc", {31'd0, tc}, 32'd0);
    step(); chk_all("up_bound2", 8'd1, 1'b0, 1'b0);
    en = 1'b0;
    step(); chk_all("up_hold", 8'd1, 1'b0, 1'b0);
`endif

    // Lower boundary.
    load = 1'b1; load_val = 8'd0; up_dn = 1'b0;
    step(); chk_all("ld0", 8'd0, 1'b0, 1'b0);
    check("ld0.tc", {31'd0, tc}, 32'd1);
    load = 1'b0; en = 1'b1;
`ifdef UPDOWN_COUNTER_SAT_EN
    step(); chk_all("dn_bound1", 8'd0, 1'b0, 1'b1);
    step(); chk_all("dn_bound2", 8'd0, 1'b0, 1'b1);
`else
    step(); chk_all("dn_bound1", 8'd9, 1'b0, 1'b1);
    step(); chk_all("dn_bound2", 8'd8, 1'b0, 1'b0);
`endif

    // Load beats enable; oversize values clamp.
    load = 1'b1; load_val = 8'd200; up_dn = 1'b1;
    step(); chk_all("clamp200", 8'd9, 1'b0, 1'b0);
    load_val = 8'd4;
    step(); chk_all("ld4", 8'd4, 1'b0, 1'b0);
    load_val = 8'd10;
    step(); chk_all("clamp10", 8'd9, 1'b0, 1'b0);

    // Hold then immediate direction reversals.
    load_val = 8'd6;
    step(); chk_all("ld6", 8'd6, 1'b0, 1'b0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk_all($sformatf("hold%0d", i), 8'd6, 1'b0, 1'b0);
    end
    en = 1'b1; up_dn = 1'b1;
    step(); chk_all("rev_up", 8'd7, 1'b0, 1'b0);
    up_dn = 1'b0;
    step(); chk_all("rev_dn", 8'd6, 1'b0, 1'b0);
    up_dn = 1'b1;
    step(); chk_all("rev_up2", 8'd7, 1'b0, 1'b0);

    // Mid-run reset.
    load = 1'b1; load_val = 8'd0;
    step(); load = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(); chk_all($sformatf("free%0d", i), i[7:0], 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    step(); chk_all("midrst", 8'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(); chk_all("resume", 8'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
